// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing master: pixel-tick divider, scan counters, registered syncs, frame marker.
// Optional VGA_SYNC_FRAME_CNT_EN adds a 16-bit frame_count output.
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        clk,
  input  logic        reset,
  output logic        p_tick,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        video_on,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [9:0] H_LAST   = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST   = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h_cnt, v_cnt;
  logic [9:0]       h_next, v_next;
  logic             frame_wrap;

  assign p_tick     = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign frame_wrap = (h_cnt == H_LAST) && (v_cnt == V_LAST);

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    h_next = h_cnt + 10'd1;
    v_next = v_cnt;
    if (h_cnt == H_LAST) begin
      h_next = 10'd0;
      v_next = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end
  end

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [15:0] frame_cnt;
  assign frame_count = frame_cnt;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt     <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
`ifdef VGA_SYNC_FRAME_CNT_EN
      frame_cnt   <= '0;
`endif
    end else begin
      frame_start <= 1'b0;
      if (p_tick) begin
        div_cnt     <= '0;
        h_cnt       <= h_next;
        v_cnt       <= v_next;
        // Syncs decode the next counts so they stay aligned with pixel_x/pixel_y.
        hsync       <= !((h_next >= HS_START) && (h_next < HS_END));
        vsync       <= !((v_next >= VS_START) && (v_next < VS_END));
        frame_start <= frame_wrap;
`ifdef VGA_SYNC_FRAME_CNT_EN
        if (frame_wrap) frame_cnt <= frame_cnt + 16'd1;
`endif
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  assign pixel_x  = h_cnt;
  assign pixel_y  = v_cnt;
  assign video_on = (h_cnt < H_VIS) && (v_cnt < V_VIS) && !reset;

endmodule
